// File: rtl/apmu_multdiv_iter.sv
// Iterative radix-2 multiplier/divider using sign-magnitude operands, with valid/ready on request and result.
// Optional abort port kill_i is enabled by defining APMU_MD_ABORT_EN.
module apmu_multdiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       op_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             data_ind_timing_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
`ifdef APMU_MD_ABORT_EN
  input  logic             kill_i,
`endif
  output logic [WIDTH-1:0] res_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned W2    = 2 * WIDTH;

  localparam logic [1:0] OP_MUL  = 2'd0;
  localparam logic [1:0] OP_MULH = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_COMP  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q;
  logic [1:0]         op_q;
  logic               sign_a_q, sign_b_q, dit_q, dbz_q;
  logic [WIDTH-1:0]   opa_q, opb_q;
  logic [W2-1:0]      acc_q;
  logic [W2-1:0]      md_q;
  logic [WIDTH-1:0]   mb_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   res_q;
  logic               ready_q, valid_q;

  logic [WIDTH-1:0]   abs_a_d, abs_b_d, mb_shr_d;
  logic [W2-1:0]      acc_mul_d, acc_div_d, prod_d;
  logic [WIDTH:0]     rem_sh_d;
  logic [WIDTH-1:0]   rem_sub_d, rem_new_d, quo_d, rem_d, res_fix_d;
  logic               div_ge_d, comp_last_d, early_dbz_d;

  assign abs_a_d = sign_a_q ? -opa_q : opa_q;
  assign abs_b_d = sign_b_q ? -opb_q : opb_q;

  // Multiply step: multiplicand shifts left, multiplier shifts right, product always exact so far.
  assign acc_mul_d = mb_q[0] ? (acc_q + md_q) : acc_q;
  assign mb_shr_d  = mb_q >> 1;

  // Restoring divide step: acc holds {remainder, dividend/quotient}.
  assign rem_sh_d  = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge_d  = rem_sh_d >= {1'b0, md_q[WIDTH-1:0]};
  assign rem_sub_d = rem_sh_d[WIDTH-1:0] - md_q[WIDTH-1:0];
  assign rem_new_d = div_ge_d ? rem_sub_d : rem_sh_d[WIDTH-1:0];
  assign acc_div_d = {rem_new_d, acc_q[WIDTH-2:0], div_ge_d};

  assign comp_last_d = (cnt_q == '0) ||
                       ((op_q == OP_MUL) && !dit_q && (mb_shr_d == '0));
  assign early_dbz_d = op_q[1] && (opb_q == '0) && !dit_q;

  // Sign fix-up and half selection.
  always_comb begin
    prod_d    = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_d     = acc_q[WIDTH-1:0];
    rem_d     = acc_q[W2-1:WIDTH];
    res_fix_d = prod_d[WIDTH-1:0];
    case (op_q)
      OP_MUL:  res_fix_d = prod_d[WIDTH-1:0];
      OP_MULH: res_fix_d = prod_d[W2-1:WIDTH];
      OP_DIV:  res_fix_d = ((sign_a_q ^ sign_b_q) && !dbz_q) ? -quo_d : quo_d;
      default: res_fix_d = sign_a_q ? -rem_d : rem_d;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dit_q    <= 1'b0;
      dbz_q    <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      md_q     <= '0;
      mb_q     <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && ready_q) begin
            op_q     <= op_i;
            sign_a_q <= op_a_i[WIDTH-1] & signed_mode_i[0];
            sign_b_q <= op_b_i[WIDTH-1] & signed_mode_i[1];
            dit_q    <= data_ind_timing_i;
            opa_q    <= op_a_i;
            opb_q    <= op_b_i;
            state_q  <= S_PREP;
            ready_q  <= 1'b0;
          end
        end
        S_PREP: begin
          cnt_q <= CNT_W'(WIDTH - 1);
          dbz_q <= (opb_q == '0);
          mb_q  <= abs_b_d;
          if (op_q[1]) begin
            acc_q <= {{WIDTH{1'b0}}, abs_a_d};
            md_q  <= {{WIDTH{1'b0}}, abs_b_d};
          end else begin
            acc_q <= '0;
            md_q  <= {{WIDTH{1'b0}}, abs_a_d};
          end
          if (early_dbz_d) begin
            res_q   <= op_q[0] ? opa_q : '1;
            state_q <= S_DONE;
            valid_q <= 1'b1;
          end else begin
            state_q <= S_COMP;
          end
        end
        S_COMP: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (op_q[1]) begin
            acc_q <= acc_div_d;
          end else begin
            acc_q <= acc_mul_d;
            md_q  <= md_q << 1;
            mb_q  <= mb_shr_d;
          end
          if (comp_last_d) state_q <= S_FIXUP;
        end
        S_FIXUP: begin
          res_q   <= res_fix_d;
          state_q <= S_DONE;
          valid_q <= 1'b1;
        end
        S_DONE: begin
          if (res_ready_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
`ifdef APMU_MD_ABORT_EN
      if (kill_i && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        valid_q <= 1'b0;
        ready_q <= 1'b1;
      end
`endif
    end
  end

  assign req_ready_o = ready_q;
  assign res_valid_o = valid_q;
  assign res_o       = res_q;

endmodule
